// File: rtl/sram_pkg.sv
// Shared types and width defaults for the SRAM sequencer/arbiter.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } sram_state_e;

  typedef struct packed {
    logic                   write;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Two-port one-hot grant: fixed priority to port 0, or round-robin when
// SRAM_ARB_ROUND_ROBIN_EN is defined (pointer moves on advance_i).
module sram_arb_grant (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Starts at port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (advance_i) last_d = grant_o[1];
  end

  always_comb begin
    grant_o = valid_i;
    if (valid_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, reset_n, advance_i};

  always_comb begin
    grant_o = valid_i;
    if (valid_i[0]) grant_o = 2'b01;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-client sequencer for an async SRAM with registered strobes and write setup/hold.
// Arbitration is fixed priority unless SRAM_ARB_ROUND_ROBIN_EN is defined.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int READ_WAIT   = 2,
  parameter int WRITE_PULSE = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_write,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      sram_addr,
  inout  wire  [DATA_W-1:0]      sram_dq,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

  sram_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  sram_req_t         req_q, req_d;
  logic              port_q, port_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] grant;
  logic       gnt_idx, accept, last_wait;

  sram_arb_grant u_grant (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid_i   (req_valid),
    .advance_i (accept),
    .grant_o   (grant)
  );

  assign req_ready = (state_q == IDLE && reset_n) ? grant : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gnt_idx   = grant[1];
  assign last_wait = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      port_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      port_q      <= port_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      dq_oe_q     <= dq_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = req_write[gnt_idx] ? WR_SETUP : READ;
      READ:     if (last_wait) state_d = IDLE;
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: if (last_wait) state_d = WR_HOLD;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Request latch, wait counter and read capture.
  always_comb begin
    req_d       = req_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 2'b00;
    if (accept) begin
      req_d.write = req_write[gnt_idx];
      req_d.addr  = SRAM_ADDR_W'(req_addr[gnt_idx]);
      req_d.wdata = SRAM_DATA_W'(req_wdata[gnt_idx]);
      port_d      = gnt_idx;
      cnt_d       = CNT_W'(READ_WAIT);
    end else if (state_q == WR_SETUP) begin
      cnt_d = CNT_W'(WRITE_PULSE);
    end else if ((state_q == READ || state_q == WR_PULSE) && !last_wait) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (state_q == READ && last_wait) begin
      rdata_d             = sram_dq;
      rsp_valid_d[port_q] = 1'b1;
    end
  end

  // Pin values are decoded from the next state so the pins come straight off flops.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    unique case (state_d)
      READ: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        ce_n_d  = 1'b0;
        dq_oe_d = req_d.write;
      end
      WR_PULSE: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = req_d.write;
      end
      default: ;
    endcase
  end

  assign sram_addr = ADDR_W'(req_q.addr);
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_dq   = dq_oe_q ? DATA_W'(req_q.wdata) : {DATA_W{1'bz}};
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Sequencer and two-port arbiter for the external asynchronous 16-bit SRAM. It accepts read and write requests from two clients, for example scanout and rasterizer. It grants one request at a time and drives the SRAM pins with registered, glitch-free strobes and correct setup and hold around the write pulse. Read data returns on a per-port response strobe. It sits between the GPU memory clients and the top-level SRAM pads.

## Interface
- ADDR_W, 20, SRAM word-address width
- DATA_W, 16, SRAM data width
- READ_WAIT, 2, cycles oe_n is held low before data capture (>=1)
- WRITE_PULSE, 2, cycles we_n is held low (>=1)
- clk  input  1  sole clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  [1:0]  per-port request valid
- req_ready  output  [1:0]  per-port accept; a transfer occurs when valid && ready at a rising edge
- req_write  input  [1:0]  1 = write, 0 = read
- req_addr  input  [1:0][ADDR_W-1:0]  word address
- req_wdata  input  [1:0][DATA_W-1:0]  write data
- rsp_valid  output  [1:0]  one-cycle pulse when read data is available
- rsp_rdata  output  [DATA_W-1:0]  read data, shared by both ports, qualified by rsp_valid
- sram_addr  output  ADDR_W  SRAM address
- sram_dq  inout  DATA_W  SRAM data; driven only during write states, otherwise 'z
- sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes

## Operation
- FSM states: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD.
- req_ready is nonzero only in IDLE and is one-hot at the granted port. It is combinational from the state and req_valid.
- In IDLE with a grant, the request is latched: address, data, write flag and port id.
- Read path: IDLE → READ for READ_WAIT cycles with ce_n=0, oe_n=0, we_n=1. sram_dq is captured at the final READ edge. The FSM then returns to IDLE, and rsp_valid[port] pulses in that IDLE cycle.
- Write path:
  - WR_SETUP, 1 cycle: ce_n=0, we_n=1, dq driven.
  - WR_PULSE, WRITE_PULSE cycles: we_n=0.
  - WR_HOLD, 1 cycle: we_n=1, dq still driven, ce_n=0.
  - Then IDLE.
- Writes are posted and produce no response.
- oe_n is never low while dq is driven. we_n is never low outside WR_PULSE.
- All sram_* outputs are registered and sram_addr is stable for the whole access.
- Wait counter width is $clog2(max(READ_WAIT, WRITE_PULSE))+1 and counts down to 1.
- Arbitration when both ports are valid: fixed priority, port 0 wins (see Configuration).
- Reset values:
  - sram_ce_n/oe_n/we_n = 1
  - sram_addr = 0
  - sram_dq = 'z
  - rsp_valid = 0, rsp_rdata = 0
  - req_ready = 0 while reset_n = 0
  - state = IDLE
- Reset mid-access: strobes deassert and dq floats immediately (asynchronous). The in-flight request is dropped with no rsp_valid.

## Timing
- Read latency: accept edge E → capture at E+READ_WAIT → rsp_valid high during the cycle following E+READ_WAIT.
- Read occupancy is READ_WAIT+1 cycles per access, counting the accepting IDLE cycle.
- Write occupancy is WRITE_PULSE+3 cycles per access.
- The next grant can occur in the IDLE cycle that carries rsp_valid, so back-to-back reads run with no bubble beyond IDLE.
- A port that holds valid low while ready is offered loses nothing, because no state is kept per port.

## Configuration
- SRAM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - A last-grant register alternates priority between the two ports.
  - It resets to port 1, so port 0 wins the first tie.
  - A single requester is granted every IDLE cycle regardless of the pointer.
- SRAM_ARB_ROUND_ROBIN_EN undefined: strict priority to port 0. Port 1 can starve, and this is acceptable for scanout-first systems.

## Structure
- The package sram_pkg holds:
  - the state enum sram_state_e
  - SRAM_ADDR_W = 20 and SRAM_DATA_W = 16 defaults
  - the request struct sram_req_t (write, addr, wdata)
- Sub-module sram_arb_grant takes valid[1:0] and an advance pulse, and returns a one-hot grant. It contains the optional round-robin pointer.

## Test plan
- Single write then read, port 0: write 0x00003 = 0xBEEF, then read 0x00003.
  - rsp_valid[0] pulses READ_WAIT cycles after the read is accepted, with rsp_rdata = 0xBEEF.
  - we_n stays low for exactly 2 cycles.
- Write strobe checker over 100 random writes:
  - dq is stable and driven during the edge before and the edge after the we_n-low window.
  - oe_n=1 whenever dq is driven.
- Simultaneous requests on both ports held for 10 accesses:
  - Without the macro, port 0 takes all 10.
  - With the macro, grants alternate 0,1,0,1.
- Back-to-back reads on port 1 with READ_WAIT=1: one rsp_valid every 2 cycles, with the data matching 16 prewritten words.
- reset_n asserted during WR_PULSE:
  - ce_n, we_n and oe_n go to 1 and dq goes to 'z before the next edge.
  - After release, no rsp_valid appears and the first new request is accepted in IDLE.
- Read with req_valid dropped on one port mid-access: the other port's response is unaffected, and rsp_valid never pulses for the idle port.
